// File: rtl/tp84_rom_pkg.sv
// Memory map and loader state encoding shared by the TimePilot84 ROM loader.
// Regions are contiguous: each base is the previous base plus its size.
package tp84_rom_pkg;

  localparam int REGION_CNT = 6;

  // Region order: main, sub, snd, tile, spr, prom.
  localparam logic [24:0] REGION_BASE [REGION_CNT] = '{
    25'h00000, 25'h08000, 25'h0A000, 25'h0C000, 25'h10000, 25'h18000
  };
  localparam logic [24:0] REGION_SIZE [REGION_CNT] = '{
    25'h08000, 25'h02000, 25'h02000, 25'h04000, 25'h08000, 25'h00500
  };

  localparam logic [24:0] TOTAL_BYTES = 25'h18500;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    DONE,
    ERR
  } ldr_state_t;

endpackage

// File: rtl/tp84_region_decode.sv
// Combinational ROM address decoder: download byte address to a one-hot region
// hit plus the region-relative offset. No hit for addresses past the last region.
module tp84_region_decode import tp84_rom_pkg::*; #(
  parameter int NUM_REGIONS = REGION_CNT,
  parameter int ADDR_W      = 16
) (
  input  logic [24:0]            addr,
  output logic [NUM_REGIONS-1:0] hit,
  output logic [ADDR_W-1:0]      offset
);

  logic [ADDR_W-1:0] part [NUM_REGIONS+1];

  assign part[0] = '0;

  // Comparing the offset against the size avoids forming base+size sums.
  for (genvar k = 0; k < NUM_REGIONS; k++) begin : g_region
    logic [24:0] rel;
    assign rel         = addr - REGION_BASE[k];
    assign hit[k]      = (addr >= REGION_BASE[k]) && (rel < REGION_SIZE[k]);
    assign part[k + 1] = part[k] | (hit[k] ? rel[ADDR_W-1:0] : '0);
  end

  assign offset = part[NUM_REGIONS];

endmodule

// File: rtl/tp84_rom_loader.sv
// Routes hps_io ioctl ROM bytes to per-region write strobes, captures DIP and
// set-3 bytes, and holds the core in reset until a clean ROM image has loaded.
module tp84_rom_loader import tp84_rom_pkg::*; #(
  parameter int NUM_REGIONS = REGION_CNT,
  parameter int ADDR_W      = 16
) (
  input  logic                   clk_49m,
  input  logic                   reset,
  input  logic                   ioctl_download,
  input  logic                   ioctl_wr,
  input  logic [24:0]            ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  input  logic [7:0]             ioctl_index,
  output logic [ADDR_W-1:0]      rom_addr,
  output logic [7:0]             rom_data,
  output logic [NUM_REGIONS-1:0] rom_we,
  output logic [15:0]            dip_sw,
  output logic                   is_set3,
  output logic                   core_hold,
  output logic                   load_done,
  output logic                   load_error
);

  ldr_state_t             state_q, state_d;
  logic [24:0]            count_q, count_d;
  logic                   overrun_q, overrun_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;
  logic [NUM_REGIONS-1:0] rom_we_q, rom_we_d;
  logic [ADDR_W-1:0]      rom_addr_q, rom_addr_d;
  logic [7:0]             rom_data_q, rom_data_d;
  logic [15:0]            dip_q, dip_d;
  logic                   set3_q, set3_d;

  logic [NUM_REGIONS-1:0] dec_hit;
  logic [ADDR_W-1:0]      dec_offset;
  logic                   rom_start;
  logic                   rom_wr;

  tp84_region_decode #(
    .NUM_REGIONS (NUM_REGIONS),
    .ADDR_W      (ADDR_W)
  ) u_decode (
    .addr   (ioctl_addr),
    .hit    (dec_hit),
    .offset (dec_offset)
  );

  assign rom_start = ioctl_download && (ioctl_index == 8'd0);
  assign rom_wr    = ioctl_wr && rom_start && (state_q == LOAD);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    overrun_d  = overrun_q;
    done_d     = done_q;
    error_d    = error_q;
    rom_we_d   = '0;
    rom_addr_d = rom_addr_q;
    rom_data_d = rom_data_q;
    dip_d      = dip_q;
    set3_d     = set3_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (rom_start) begin
          state_d   = LOAD;
          count_d   = '0;
          overrun_d = 1'b0;
          done_d    = 1'b0;
          error_d   = 1'b0;
        end
      end
      LOAD: begin
        if (!ioctl_download) state_d = CHECK;
      end
      CHECK: begin
        if ((count_q == TOTAL_BYTES) && !overrun_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ERR;
          error_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Bytes beyond the image still count, so over-long images fail the check twice over.
    if (rom_wr) begin
      if (count_q != '1) count_d = count_q + 25'd1;
      if (ioctl_addr >= TOTAL_BYTES) overrun_d = 1'b1;
      rom_we_d   = dec_hit;
      rom_addr_d = dec_offset;
      rom_data_d = ioctl_dout;
    end

    if (ioctl_wr && ioctl_download && (ioctl_index == 8'd254) && (ioctl_addr[24:1] == '0)) begin
      if (ioctl_addr[0]) dip_d[15:8] = ~ioctl_dout;
      else               dip_d[7:0]  = ~ioctl_dout;
    end

    if (ioctl_wr && ioctl_download && (ioctl_index == 8'd1) && (ioctl_addr == '0)) begin
      set3_d = ioctl_dout[0];
    end
  end

  always_ff @(posedge clk_49m) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      rom_we_q   <= '0;
      rom_addr_q <= '0;
      rom_data_q <= '0;
      dip_q      <= 16'hFFFF;
      set3_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      done_q     <= done_d;
      error_q    <= error_d;
      rom_we_q   <= rom_we_d;
      rom_addr_q <= rom_addr_d;
      rom_data_q <= rom_data_d;
      dip_q      <= dip_d;
      set3_q     <= set3_d;
    end
  end

  assign rom_we     = rom_we_q;
  assign rom_addr   = rom_addr_q;
  assign rom_data   = rom_data_q;
  assign dip_sw     = dip_q;
  assign is_set3    = set3_q;
  assign core_hold  = (state_q != DONE);
  assign load_done  = done_q;
  assign load_error = error_q;

endmodule

// File: tb/tb_tp84_rom_loader.sv
// Scoreboard bench for tp84_rom_loader: drivers queue the expected ROM writes,
// a monitor pops and compares each strobe; status outputs are checked directly.
module tb_tp84_rom_loader;

  logic        clk_49m = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  ioctl_index;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic [5:0]  rom_we;
  logic [15:0] dip_sw;
  logic        is_set3;
  logic        core_hold;
  logic        load_done;
  logic        load_error;

  typedef struct packed {
    logic [5:0]  we;
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t sbQueue[$];
  int   total       = 0;
  int   bad         = 0;
  int   strobeCount = 0;

  always #5 clk_49m = ~clk_49m;

  tp84_rom_loader #(
    .NUM_REGIONS (6),
    .ADDR_W      (16)
  ) dut (
    .clk_49m        (clk_49m),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .rom_we         (rom_we),
    .dip_sw         (dip_sw),
    .is_set3        (is_set3),
    .core_hold      (core_hold),
    .load_done      (load_done),
    .load_error     (load_error)
  );

  // Hand-written memory map: region k spans bounds[k] .. bounds[k+1]-1.
  function automatic void modelLookup(input int a, output logic [5:0] we, output logic [15:0] off);
    int bounds [7] = '{'h0, 'h8000, 'hA000, 'hC000, 'h10000, 'h18000, 'h18500};
    we  = '0;
    off = '0;
    for (int k = 0; k < 6; k++) begin
      if (a >= bounds[k] && a < bounds[k + 1]) begin
        we  = 6'(1 << k);
        off = 16'(a - bounds[k]);
      end
    end
  endfunction

  function automatic logic [7:0] dataOf(input int a);
    return 8'(a ^ (a >> 8) ^ 'h5A);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk_49m);
      #1;
    end
  endtask

  task automatic applyStimulus(input int a, input logic [7:0] d, input bit expectStrobe);
    exp_t        e;
    logic [5:0]  we;
    logic [15:0] off;
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'(a);
    ioctl_dout = d;
    if (expectStrobe) begin
      modelLookup(a, we, off);
      if (we != '0) begin
        e.we   = we;
        e.addr = off;
        e.data = d;
        sbQueue.push_back(e);
      end
    end
    cycles(1);
    ioctl_wr = 1'b0;
  endtask

  task automatic beginDownload(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    cycles(1);
  endtask

  task automatic endDownload();
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    cycles(1);
  endtask

  task automatic runMonitor();
    exp_t e;
    forever begin
      @(negedge clk_49m);
      if (rom_we !== '0) begin
        strobeCount++;
        total++;
        if (sbQueue.size() == 0) begin
          bad++;
          $display("[TB] FAIL sb_unexpected: got we=%b addr=%h data=%h want no strobe",
                   rom_we, rom_addr, rom_data);
        end else begin
          e = sbQueue.pop_front();
          if ({rom_we, rom_addr, rom_data} !== e) begin
            bad++;
            $display("[TB] FAIL sb_write: got we=%b addr=%h data=%h want we=%b addr=%h data=%h",
                     rom_we, rom_addr, rom_data, e.we, e.addr, e.data);
          end
        end
      end
    end
  endtask

  task automatic runTests();
    int edges [9] = '{'h9FFF, 'hA000, 'hBFFF, 'hC000, 'hFFFF, 'h10000, 'h17FFF, 'h18000, 'h184FF};
    int startCnt;

    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    ioctl_index    = '0;
    cycles(3);
    @(negedge clk_49m);
    checkOutput("rst_we", rom_we, 0);
    checkOutput("rst_addr", rom_addr, 0);
    checkOutput("rst_data", rom_data, 0);
    checkOutput("rst_dip", dip_sw, 'hFFFF);
    checkOutput("rst_set3", is_set3, 0);
    checkOutput("rst_hold", core_hold, 1);
    checkOutput("rst_done", load_done, 0);
    checkOutput("rst_err", load_error, 0);
    reset = 1'b0;
    cycles(1);

    $display("[TB] reset during load");
    beginDownload(8'd0);
    for (int a = 0; a < 'h100; a++) applyStimulus(a, dataOf(a), 1'b1);
    reset      = 1'b1;
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h100;
    ioctl_dout = 8'hC3;
    cycles(1);
    reset          = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    @(negedge clk_49m);
    checkOutput("rst_mid_we", rom_we, 0);
    checkOutput("rst_mid_hold", core_hold, 1);
    applyStimulus('h20, 8'h77, 1'b0);
    cycles(3);
    @(negedge clk_49m);
    checkOutput("rst_mid_err", load_error, 0);
    checkOutput("rst_mid_done", load_done, 0);
    checkOutput("rst_mid_drain", sbQueue.size(), 0);

    $display("[TB] dip and set flag");
    beginDownload(8'd254);
    applyStimulus(0, 8'h5A, 1'b0);
    applyStimulus(1, 8'h0F, 1'b0);
    applyStimulus(2, 8'h33, 1'b0);
    endDownload();
    @(negedge clk_49m);
    checkOutput("dip_sw", dip_sw, 'hF0A5);
    checkOutput("dip_hold", core_hold, 1);
    checkOutput("dip_err", load_error, 0);
    beginDownload(8'd1);
    applyStimulus(0, 8'h01, 1'b0);
    applyStimulus(1, 8'h00, 1'b0);
    endDownload();
    @(negedge clk_49m);
    checkOutput("set3", is_set3, 1);
    checkOutput("set3_hold", core_hold, 1);

    $display("[TB] region boundaries, short image");
    beginDownload(8'd0);
    applyStimulus('h7FFF, 8'hA7, 1'b1);
    @(negedge clk_49m);
    checkOutput("bnd0_we", rom_we, 'b000001);
    checkOutput("bnd0_addr", rom_addr, 'h7FFF);
    applyStimulus('h8000, 8'h3C, 1'b1);
    @(negedge clk_49m);
    checkOutput("bnd1_we", rom_we, 'b000010);
    checkOutput("bnd1_addr", rom_addr, 'h0000);
    for (int i = 0; i < 9; i++) applyStimulus(edges[i], dataOf(edges[i]), 1'b1);
    endDownload();
    @(negedge clk_49m);
    checkOutput("short_check_hold", core_hold, 1);
    cycles(1);
    @(negedge clk_49m);
    checkOutput("short_err", load_error, 1);
    checkOutput("short_done", load_done, 0);
    checkOutput("short_hold", core_hold, 1);
    checkOutput("short_drain", sbQueue.size(), 0);

    $display("[TB] over-long image");
    beginDownload(8'd0);
    @(negedge clk_49m);
    checkOutput("restart_err_clr", load_error, 0);
    for (int a = 'h18480; a < 'h18500; a++) applyStimulus(a, dataOf(a), 1'b1);
    applyStimulus('h18500, 8'hEE, 1'b0);
    applyStimulus('h1FFFF, 8'hDD, 1'b0);
    endDownload();
    cycles(1);
    @(negedge clk_49m);
    checkOutput("long_err", load_error, 1);
    checkOutput("long_done", load_done, 0);
    checkOutput("long_hold", core_hold, 1);
    checkOutput("long_drain", sbQueue.size(), 0);

    $display("[TB] full image");
    beginDownload(8'd0);
    startCnt = strobeCount;
    for (int a = 0; a < 'h18500; a++) applyStimulus(a, dataOf(a), 1'b1);
    endDownload();
    @(negedge clk_49m);
    checkOutput("full_check_hold", core_hold, 1);
    checkOutput("full_check_done", load_done, 0);
    cycles(1);
    @(negedge clk_49m);
    checkOutput("full_done", load_done, 1);
    checkOutput("full_hold", core_hold, 0);
    checkOutput("full_err", load_error, 0);
    cycles(2);
    checkOutput("full_strobes", strobeCount - startCnt, 'h18500);
    checkOutput("full_drain", sbQueue.size(), 0);
    checkOutput("full_dip_kept", dip_sw, 'hF0A5);
    checkOutput("full_set3_kept", is_set3, 1);
    applyStimulus('h10, 8'h99, 1'b0);
    cycles(2);
    @(negedge clk_49m);
    checkOutput("done_sticky", load_done, 1);
    checkOutput("done_hold", core_hold, 0);
  endtask

  initial begin
    fork
      runMonitor();
      runTests();
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
